// File: rtl/key_repeat_ctrl_pkg.sv
// Shared definitions for the key repeat controller: channel FSM encoding,
// channel indices and default timing at a 50 MHz system clock.
package key_repeat_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DAS_WAIT = 2'd1,
    ST_REPEAT   = 2'd2
  } ch_state_e;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;
  localparam int unsigned CH_ROT   = 2;
  localparam int unsigned CH_DROP  = 3;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int unsigned DEF_DAS_CYCLES      = 12500000;
  localparam int unsigned DEF_ARR_CYCLES      = 2500000;
  localparam logic [3:0]  DEF_REPEAT_MASK     = 4'b0011;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_repeat_ctrl_channel.sv
// One key: 2-flop synchronizer, debounce, press/DAS/repeat FSM. The move
// request is exported unregistered so the top can gate left/right together.
module key_channel
  import key_repeat_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DAS_CYCLES      = DEF_DAS_CYCLES,
  parameter int unsigned ARR_CYCLES      = DEF_ARR_CYCLES,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_key_n,
  output logic o_level,
  output logic o_pulse_c
);

  localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYCLES, DAS_CYCLES, ARR_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_deb_cnt;
  ch_state_e        r_state;
  ch_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_hold;
  logic [CNT_W-1:0] w_hold_nxt;
  logic             w_pulse_nxt;
  logic             w_differ;
  logic             w_deb_done;
  logic             w_rise;
  logic             w_fall;

  // Inverted ahead of the first flop so the reset value 0 means "not pressed".
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= ~i_key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_differ   = r_sync2 ^ r_level;
  assign w_deb_done = w_differ && (r_deb_cnt == DEB_MAX);
  assign w_rise     = w_deb_done && !r_level;
  assign w_fall     = w_deb_done && r_level;

  // Debounce: count consecutive disagreeing cycles, toggle level at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_level   <= 1'b0;
      r_deb_cnt <= '0;
    end else if (!w_differ) begin
      r_deb_cnt <= '0;
    end else if (w_deb_done) begin
      r_deb_cnt <= '0;
      r_level   <= ~r_level;
    end else begin
      r_deb_cnt <= r_deb_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Release wins over a repeat due in the same cycle; the hold timer saturates.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_pulse_nxt = 1'b0;
    if (w_fall) begin
      w_state_nxt = ST_IDLE;
      w_hold_nxt  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt = ST_DAS_WAIT;
            w_hold_nxt  = '0;
            w_pulse_nxt = 1'b1;
          end
        end
        ST_DAS_WAIT: begin
          if (r_hold >= DAS_LAST) begin
            if (REPEAT_EN) begin
              w_state_nxt = ST_REPEAT;
              w_hold_nxt  = '0;
              w_pulse_nxt = 1'b1;
            end
          end else begin
            w_hold_nxt = r_hold + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (r_hold >= ARR_LAST) begin
            w_hold_nxt  = '0;
            w_pulse_nxt = 1'b1;
          end else begin
            w_hold_nxt = r_hold + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_hold_nxt  = '0;
        end
      endcase
    end
  end

  assign o_level   = r_level;
  assign o_pulse_c = w_pulse_nxt;

endmodule

// File: rtl/key_repeat_ctrl.sv
// Four debounced, auto-repeating key channels; simultaneous left+right
// requests cancel so the move mux never sees a contradictory command.
module key_repeat_ctrl
  import key_repeat_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned DAS_CYCLES      = DEF_DAS_CYCLES,
  parameter int unsigned ARR_CYCLES      = DEF_ARR_CYCLES,
  parameter logic [3:0]  REPEAT_MASK     = DEF_REPEAT_MASK
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  output logic [3:0] level,
  output logic [3:0] pulse
);

  logic [3:0] w_level;
  logic [3:0] w_pulse_c;
  logic [3:0] w_pulse_gated;
  logic [3:0] r_pulse;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DAS_CYCLES      (DAS_CYCLES),
      .ARR_CYCLES      (ARR_CYCLES),
      .REPEAT_EN       (REPEAT_MASK[gi])
    ) u_ch (
      .clk       (clk),
      .resetn    (resetn),
      .i_key_n   (key_n[gi]),
      .o_level   (w_level[gi]),
      .o_pulse_c (w_pulse_c[gi])
    );
  end

  // Channel FSMs advance regardless; only the issued request is dropped.
  always_comb begin
    w_pulse_gated = w_pulse_c;
    if (w_pulse_c[CH_LEFT] && w_pulse_c[CH_RIGHT]) begin
      w_pulse_gated[CH_LEFT]  = 1'b0;
      w_pulse_gated[CH_RIGHT] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pulse <= '0;
    end else begin
      r_pulse <= w_pulse_gated;
    end
  end

  assign level = w_level;
  assign pulse = r_pulse;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl with short timing (debounce 4, DAS 10, ARR 3).
// Cycle c is the interval after rising edge c; inputs for cycle c change before edge c.
module tb_key_repeat_ctrl;

  logic       clk;
  logic       resetn;
  logic [3:0] key_n;
  logic [3:0] level;
  logic [3:0] pulse;
  int         n_cmp;
  int         n_bad;

  key_repeat_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DAS_CYCLES      (10),
    .ARR_CYCLES      (3),
    .REPEAT_MASK     (4'b0011)
  ) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .key_n  (key_n),
    .level  (level),
    .pulse  (pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] key_of(input int tc, input int c);
    case (tc)
      1: return (c < 30) ? 4'b1110 : 4'b1111;
      2: return (c < 30) ? 4'b1011 : 4'b1111;
      3: return (c <= 2 || (c >= 4 && c <= 6)) ? 4'b1101 : 4'b1111;
      4: return (c < 22) ? 4'b1100 : 4'b1111;
      5: return 4'b1110;
      6: return (c < 13) ? 4'b1110 : 4'b1111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [3:0] pulse_of(input int tc, input int c);
    case (tc)
      1: return (c == 6 || c == 16 || c == 19 || c == 22 || c == 25 || c == 28) ? 4'b0001 : 4'b0000;
      2: return (c == 6) ? 4'b0100 : 4'b0000;
      5: return (c == 6 || c == 20) ? 4'b0001 : 4'b0000;
      6: return (c == 6 || c == 16) ? 4'b0001 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] level_of(input int tc, input int c);
    case (tc)
      1: return (c >= 6) ? 4'b0001 : 4'b0000;
      2: return (c >= 6) ? 4'b0100 : 4'b0000;
      4: return (c >= 6) ? 4'b0011 : 4'b0000;
      5: return ((c >= 6 && c < 12) || c >= 20) ? 4'b0001 : 4'b0000;
      6: return (c >= 6 && c < 19) ? 4'b0001 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic int ncyc_of(input int tc);
    case (tc)
      3: return 20;
      4: return 22;
      5: return 28;
      default: return 30;
    endcase
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    resetn = 1'b0;
    key_n  = 4'b1111;
    repeat (3) @(posedge clk);
    #1;
    chk("reset level", level, 4'b0000);
    chk("reset pulse", pulse, 4'b0000);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic run(input int tc, input int ncyc);
    reset_dut();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      key_n = key_of(tc, c);
      if (tc == 5 && c == 12) begin
        resetn = 1'b0;
        #1;
        chk("t5 async level", level, 4'b0000);
        chk("t5 async pulse", pulse, 4'b0000);
      end
      if (tc == 5 && c == 14) resetn = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("t%0d pulse c%0d", tc, c), pulse, pulse_of(tc, c));
      chk($sformatf("t%0d level c%0d", tc, c), level, level_of(tc, c));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    resetn = 1'b0;
    key_n  = 4'b1111;
    for (int tc = 1; tc <= 6; tc++) begin
      run(tc, ncyc_of(tc));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
